// File: rtl/rtr_nha_sched_pkg.sv
// rtl/rtr_nha_sched_pkg.sv - shared router constants and helper functions
package rtr_nha_sched_pkg;

   localparam int CONNECTIVITY_LINE = 0;
   localparam int CONNECTIVITY_RING = 1;
   localparam int CONNECTIVITY_FULL = 2;

   localparam int ROUTING_TYPE_PHASED_DOR = 0;

   // ceil(log2(value)); a single item needs no index bits
   function automatic int clogb(input int value);
      int v;
      int n;
      v = value - 1;
      n = 0;
      while (v > 0) begin
         n++;
         v = v >> 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/rtr_nha_sched_next_hop_addr.sv
// rtl/rtr_nha_sched_next_hop_addr.sv - next router address from lookahead port selection
module rtr_next_hop_addr
   import rtr_nha_sched_pkg::*;
#(
   parameter int num_resource_classes = 2,
   parameter int num_routers_per_dim  = 4,
   parameter int num_dimensions       = 2,
   parameter int num_nodes_per_router = 1,
   parameter int connectivity         = CONNECTIVITY_LINE,
   parameter int routing_type         = ROUTING_TYPE_PHASED_DOR,
   localparam int dim_addr_width    = clogb(num_routers_per_dim),
   localparam int router_addr_width = num_dimensions * dim_addr_width,
   localparam int num_ports         = num_nodes_per_router + 2 * num_dimensions,
   localparam int port_idx_width    = clogb(num_ports),
   localparam int rc_idx_width      = (num_resource_classes > 1) ? clogb(num_resource_classes) : 1,
   localparam int lar_info_width    = port_idx_width + rc_idx_width,
   localparam int dest_info_width   = num_resource_classes * router_addr_width
) (
   input  logic [router_addr_width-1:0] router_address,
   input  logic [dest_info_width-1:0]   dest_info,
   input  logic [lar_info_width-1:0]    lar_info,
   output logic [router_addr_width-1:0] next_router_address
);

   logic [port_idx_width-1:0]    port;
   logic [rc_idx_width-1:0]      rcsel;
   logic [router_addr_width-1:0] dest_addr;
   logic [dim_addr_width-1:0]    cur;
   logic [dim_addr_width-1:0]    tgt;
   logic [dim_addr_width-1:0]    hop;
   logic                         up;
   int                           rc;

   assign port  = lar_info[lar_info_width-1 -: port_idx_width];
   assign rcsel = lar_info[rc_idx_width-1:0];

   always_comb begin
      rc = 0;
      if (routing_type == ROUTING_TYPE_PHASED_DOR && int'(rcsel) < num_resource_classes)
         rc = int'(rcsel);
      dest_addr = dest_info[(num_resource_classes-1-rc)*router_addr_width +: router_addr_width];
   end

   // Port 2d/2d+1 moves down/up in dimension d (dim0 in the MSB slice); other ports stay here
   always_comb begin
      next_router_address = router_address;
      cur = '0;
      tgt = '0;
      hop = '0;
      up  = 1'b0;
      for (int d = 0; d < num_dimensions; d++) begin
         cur = router_address[(num_dimensions-1-d)*dim_addr_width +: dim_addr_width];
         tgt = dest_addr[(num_dimensions-1-d)*dim_addr_width +: dim_addr_width];
         if (int'(port) == 2*d || int'(port) == 2*d + 1) begin
            up = (int'(port) == 2*d + 1);
            case (connectivity)
               CONNECTIVITY_RING: begin
                  if (up)
                     hop = (int'(cur) == num_routers_per_dim - 1) ? '0 : cur + dim_addr_width'(1);
                  else
                     hop = (cur == '0) ? dim_addr_width'(num_routers_per_dim - 1)
                                       : cur - dim_addr_width'(1);
               end
               CONNECTIVITY_FULL: hop = tgt;
               default:           hop = up ? cur + dim_addr_width'(1) : cur - dim_addr_width'(1);
            endcase
            next_router_address[(num_dimensions-1-d)*dim_addr_width +: dim_addr_width] = hop;
         end
      end
   end

endmodule

// File: rtl/rtr_nha_sched.sv
// rtl/rtr_nha_sched.sv - round-robin sharing of one next-hop address unit with a one-entry result stage
module rtr_nha_sched
   import rtr_nha_sched_pkg::*;
#(
   parameter int num_requesters       = 4,
   parameter int num_resource_classes = 2,
   parameter int num_routers_per_dim  = 4,
   parameter int num_dimensions       = 2,
   parameter int num_nodes_per_router = 1,
   parameter int connectivity         = CONNECTIVITY_LINE,
   parameter int routing_type         = ROUTING_TYPE_PHASED_DOR,
   localparam int dim_addr_width    = clogb(num_routers_per_dim),
   localparam int router_addr_width = num_dimensions * dim_addr_width,
   localparam int num_ports         = num_nodes_per_router + 2 * num_dimensions,
   localparam int port_idx_width    = clogb(num_ports),
   localparam int rc_idx_width      = (num_resource_classes > 1) ? clogb(num_resource_classes) : 1,
   localparam int lar_info_width    = port_idx_width + rc_idx_width,
   localparam int dest_info_width   = num_resource_classes * router_addr_width,
   localparam int id_width          = clogb(num_requesters)
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [router_addr_width-1:0]               router_address,
   input  logic [num_requesters-1:0]                  req,
   input  logic [num_requesters*dest_info_width-1:0]  req_dest_info,
   input  logic [num_requesters*lar_info_width-1:0]   req_lar_info,
   output logic [num_requesters-1:0]                  gnt,
   output logic                                       resp_valid,
   input  logic                                       resp_ready,
   output logic [id_width-1:0]                        resp_id,
   output logic [router_addr_width-1:0]               resp_next_router_address
);

   logic [id_width-1:0]          prio_ptr_q, prio_ptr_d;
   logic                         resp_valid_q, resp_valid_d;
   logic [id_width-1:0]          resp_id_q, resp_id_d;
   logic [router_addr_width-1:0] resp_addr_q, resp_addr_d;
   logic                         load_ok;
   logic                         found;
   logic [id_width-1:0]          win_idx;
   logic [id_width-1:0]          cand_idx;
   logic [dest_info_width-1:0]   sel_dest;
   logic [lar_info_width-1:0]    sel_lar;
   logic [router_addr_width-1:0] nha_addr;

   assign load_ok = ~resp_valid_q | resp_ready;

   // First requester at or after the pointer wins; gnt is held off during reset
   always_comb begin
      gnt      = '0;
      found    = 1'b0;
      win_idx  = '0;
      cand_idx = '0;
      if (load_ok && reset) begin
         for (int k = 0; k < num_requesters; k++) begin
            cand_idx = id_width'((int'(prio_ptr_q) + k) % num_requesters);
            if (!found && req[cand_idx]) begin
               found   = 1'b1;
               win_idx = cand_idx;
            end
         end
         gnt[win_idx] = found;
      end
   end

   assign sel_dest = req_dest_info[(num_requesters-1-int'(win_idx))*dest_info_width +: dest_info_width];
   assign sel_lar  = req_lar_info[(num_requesters-1-int'(win_idx))*lar_info_width +: lar_info_width];

   rtr_next_hop_addr #(
      .num_resource_classes (num_resource_classes),
      .num_routers_per_dim  (num_routers_per_dim),
      .num_dimensions       (num_dimensions),
      .num_nodes_per_router (num_nodes_per_router),
      .connectivity         (connectivity),
      .routing_type         (routing_type)
   ) u_next_hop_addr (
      .router_address      (router_address),
      .dest_info           (sel_dest),
      .lar_info            (sel_lar),
      .next_router_address (nha_addr)
   );

   always_comb begin
      prio_ptr_d   = found ? id_width'((int'(win_idx) + 1) % num_requesters) : prio_ptr_q;
      resp_valid_d = found | (resp_valid_q & ~resp_ready);
      resp_id_d    = found ? win_idx : resp_id_q;
      resp_addr_d  = found ? nha_addr : resp_addr_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio_ptr_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_addr_q  <= '0;
      end else begin
         prio_ptr_q   <= prio_ptr_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_addr_q  <= resp_addr_d;
      end
   end

   assign resp_valid               = resp_valid_q;
   assign resp_id                  = resp_id_q;
   assign resp_next_router_address = resp_addr_q;

endmodule

// File: tb/tb_rtr_nha_sched.sv
// tb/tb_rtr_nha_sched.sv - directed self-checking bench for rtr_nha_sched
module tb_rtr_nha_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  router_address;
   logic [3:0]  req;
   logic [31:0] req_dest_info;
   logic [15:0] req_lar_info;
   logic [3:0]  gnt;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_id;
   logic [3:0]  resp_next_router_address;

   int total = 0;
   int bad   = 0;

   int         t_r[5]    = '{3, 0, 1, 2, 3};
   logic [2:0] t_port[5] = '{3'd4, 3'd3, 3'd7, 3'd0, 3'd5};
   logic [3:0] t_addr[5] = '{4'b0110, 4'b0111, 4'b0110, 4'b0010, 4'b0110};

   always #5 clk = ~clk;

   rtr_nha_sched dut (
      .clk                      (clk),
      .reset                    (reset),
      .router_address           (router_address),
      .req                      (req),
      .req_dest_info            (req_dest_info),
      .req_lar_info             (req_lar_info),
      .gnt                      (gnt),
      .resp_valid               (resp_valid),
      .resp_ready               (resp_ready),
      .resp_id                  (resp_id),
      .resp_next_router_address (resp_next_router_address)
   );

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lar(input int r, input logic [2:0] port);
      req_lar_info[(3-r)*4 +: 4] = {port, 1'b0};
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req = 4'b0000;
      resp_ready = 1'b0;
      router_address = 4'b0110;
      req_dest_info = '0;
      req_lar_info = '0;
      repeat (2) @(posedge clk);
      #1;
      req = 4'b1111;
      #1;
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt_low: got %b want 0000", gnt); end
      #1;
      reset = 1'b1;
      req = 4'b0000;
      cycle();
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
      total++;
      if (resp_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", resp_id); end
      total++;
      if (resp_next_router_address !== 4'b0000)
         begin bad++; $display("FAIL reset_addr: got %b want 0000", resp_next_router_address); end
   endtask

   task automatic test_single();
      req = 4'b0001;
      set_lar(0, 3'd1);
      resp_ready = 1'b1;
      #1;
      total++;
      if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", gnt); end
      cycle();
      req = 4'b0000;
      total++;
      if (resp_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", resp_valid); end
      total++;
      if (resp_id !== 2'd0) begin bad++; $display("FAIL single_id: got %0d want 0", resp_id); end
      total++;
      if (resp_next_router_address !== 4'b1010)
         begin bad++; $display("FAIL single_addr: got %b want 1010", resp_next_router_address); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt;
      apply_reset();
      for (int r = 0; r < 4; r++) set_lar(r, 3'd1);
      req = 4'b1111;
      resp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_gnt = 4'(1 << (k % 4));
         #1;
         total++;
         if (gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_gnt); end
         cycle();
         total++;
         if (resp_valid !== 1'b1 || resp_id !== 2'(k % 4))
            begin bad++; $display("FAIL rr_id[%0d]: got valid=%b id=%0d want valid=1 id=%0d", k, resp_valid, resp_id, k % 4); end
      end
      req = 4'b0000;
      cycle();
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL rr_drain: got %b want 0", resp_valid); end
   endtask

   task automatic test_backpressure();
      set_lar(1, 3'd1);
      req = 4'b0010;
      resp_ready = 1'b0;
      #1;
      total++;
      if (gnt !== 4'b0010) begin bad++; $display("FAIL bp_fill_gnt: got %b want 0010", gnt); end
      cycle();
      req = 4'b0100;
      set_lar(2, 3'd2);
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (gnt !== 4'b0000) begin bad++; $display("FAIL bp_gnt_hold[%0d]: got %b want 0000", k, gnt); end
         total++;
         if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_next_router_address !== 4'b1010)
            begin bad++; $display("FAIL bp_hold[%0d]: got valid=%b id=%0d addr=%b want 1/1/1010", k, resp_valid, resp_id, resp_next_router_address); end
         cycle();
      end
      resp_ready = 1'b1;
      #1;
      total++;
      if (gnt !== 4'b0100) begin bad++; $display("FAIL bp_refill_gnt: got %b want 0100", gnt); end
      cycle();
      req = 4'b0000;
      total++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_next_router_address !== 4'b0101)
         begin bad++; $display("FAIL bp_refill: got valid=%b id=%0d addr=%b want 1/2/0101", resp_valid, resp_id, resp_next_router_address); end
      cycle();
      total++;
      if (resp_valid !== 1'b0 || resp_id !== 2'd2 || resp_next_router_address !== 4'b0101)
         begin bad++; $display("FAIL bp_empty_hold: got valid=%b id=%0d addr=%b want 0/2/0101", resp_valid, resp_id, resp_next_router_address); end
   endtask

   task automatic test_ports();
      resp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         req = 4'(1 << t_r[k]);
         set_lar(t_r[k], t_port[k]);
         #1;
         total++;
         if (gnt !== 4'(1 << t_r[k])) begin bad++; $display("FAIL port_gnt[%0d]: got %b want %b", k, gnt, 4'(1 << t_r[k])); end
         cycle();
         total++;
         if (resp_id !== 2'(t_r[k]) || resp_next_router_address !== t_addr[k])
            begin bad++; $display("FAIL port_addr[%0d]: got id=%0d addr=%b want id=%0d addr=%b", k, resp_id, resp_next_router_address, t_r[k], t_addr[k]); end
      end
      req = 4'b0000;
      cycle();
   endtask

   task automatic test_reset_mid();
      set_lar(1, 3'd1);
      req = 4'b0010;
      resp_ready = 1'b0;
      #1;
      total++;
      if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_pre_gnt: got %b want 0010", gnt); end
      cycle();
      req = 4'b0000;
      total++;
      if (resp_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", resp_valid); end
      #2;
      reset = 1'b0;
      req = 4'b0110;
      #1;
      total++;
      if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_next_router_address !== 4'b0000)
         begin bad++; $display("FAIL mid_async_clear: got valid=%b id=%0d addr=%b want 0/0/0000", resp_valid, resp_id, resp_next_router_address); end
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_gnt_in_reset: got %b want 0000", gnt); end
      #1;
      reset = 1'b1;
      set_lar(1, 3'd2);
      resp_ready = 1'b1;
      #1;
      total++;
      if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_ptr_restart: got %b want 0010", gnt); end
      cycle();
      req = 4'b0000;
      total++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_next_router_address !== 4'b0101)
         begin bad++; $display("FAIL mid_post: got valid=%b id=%0d addr=%b want 1/1/0101", resp_valid, resp_id, resp_next_router_address); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_ports();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
